// File: rtl/bttn_pkg.sv
// Shared definitions for the button-driven ALU sequencer: opcodes, display
// select codes and the FSM state encoding.
package bttn_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_ACC = 3'b111;

   localparam logic [1:0] SEL_RES  = 2'b00;
   localparam logic [1:0] SEL_OPS  = 2'b01;
   localparam logic [1:0] SEL_STAT = 2'b10;
   localparam logic [1:0] SEL_OFF  = 2'b11;

   // The numeric codes are visible on the display bus, so they are fixed.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bttn_debounce.sv
// Start-button conditioning: two-flop synchroniser, optional debounce and a
// one-cycle rising-edge pulse. The debounce stage exists only when the
// BTTN_DEBOUNCE_EN macro is defined; otherwise the synchronised level feeds
// the edge detector directly and DEB_CYCLES has no effect.
module bttn_debounce #(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);

   logic sync_1;
   logic sync_2;
   logic level;
   logic level_d;

   // Bring the asynchronous button into the clk domain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
      end
   end

`ifdef BTTN_DEBOUNCE_EN
   localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYCLES - 1);

   logic [CNT_W-1:0] deb_cnt;

   // Down-counter restarts whenever the input agrees with the held level; the
   // level only flips after DEB_CYCLES consecutive disagreeing edges.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level   <= 1'b0;
         deb_cnt <= CNT_LOAD;
      end else if (sync_2 == level) begin
         deb_cnt <= CNT_LOAD;
      end else if (deb_cnt == '0) begin
         level   <= sync_2;
         deb_cnt <= CNT_LOAD;
      end else begin
         deb_cnt <= deb_cnt - 1'b1;
      end
   end
`else
   assign level = sync_2;
`endif

   // Previous sample of the conditioned level for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_d <= 1'b0;
      end else begin
         level_d <= level;
      end
   end

   assign pulse = level & ~level_d;

endmodule

// File: rtl/bttn_alu_seq.sv
// Button-driven ALU sequencer: captures operands/opcode on a start edge,
// executes one of eight operations (multiply is iterative shift-add), holds
// result and flags, and drives a display bus and two LEDs.
// Optional start debounce is enabled by defining BTTN_DEBOUNCE_EN.
//
//   state | meaning
//   IDLE  | waiting for an accepted start edge
//   EXEC  | operation running (one edge, or WIDTH edges for MUL)
//   DONE  | result just written, done pulse for one cycle
//
// The status display view packs op, state and led into 7 bits, so WIDTH >= 3.
module bttn_alu_seq
   import bttn_pkg::*;
#(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [2:0]           opCode,
   input  logic [1:0]           select,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           led,
   output logic [3*WIDTH-1:0]   Y
);

   localparam int unsigned RW    = 3 * WIDTH;
   localparam int unsigned SW    = 4 * WIDTH;
   localparam int unsigned AW    = RW + 1;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   state_t             state_q;
   state_t             state_nxt;
   logic               start_pulse;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2:0]         op_q;
   logic [RW-1:0]      r_q;
   logic [1:0]         led_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] prod_step;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH-1:0]   sub_diff;
   logic [AW-1:0]      acc_sum;
   logic [SW-1:0]      shl_wide;
   logic [RW-1:0]      res_alu;
   logic               carry_alu;

   bttn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (start),
      .pulse (start_pulse)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state logic; start edges outside IDLE are simply ignored.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE: if (start_pulse) state_nxt = EXEC;
         EXEC: if ((op_q != OP_MUL) || (cnt_q == '0)) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      busy = (state_q == EXEC);
      done = (state_q == DONE);
   end

   // Single-cycle operation results and carry/borrow flag.
   always_comb begin
      res_alu   = '0;
      carry_alu = 1'b0;
      add_sum   = {1'b0, a_q} + {1'b0, b_q};
      sub_diff  = a_q - b_q;
      acc_sum   = {1'b0, r_q} + AW'(a_q);
      shl_wide  = SW'(a_q) << b_q;
      case (op_q)
         OP_ADD: begin
            res_alu   = RW'(add_sum);
            carry_alu = add_sum[WIDTH];
         end
         OP_SUB: begin
            res_alu   = RW'(sub_diff);
            carry_alu = (a_q < b_q);
         end
         OP_AND: res_alu = RW'(a_q & b_q);
         OP_OR:  res_alu = RW'(a_q | b_q);
         OP_XOR: res_alu = RW'(a_q ^ b_q);
         OP_SHL: begin
            // Below RW the shifted operand fits in SW bits, so the top
            // WIDTH bits hold exactly what fell off the result.
            if (32'(b_q) >= RW) begin
               res_alu   = '0;
               carry_alu = |a_q;
            end else begin
               res_alu   = shl_wide[RW-1:0];
               carry_alu = |shl_wide[SW-1:RW];
            end
         end
         OP_ACC: begin
            res_alu   = acc_sum[RW-1:0];
            carry_alu = acc_sum[RW];
         end
         default: begin
            res_alu   = '0;
            carry_alu = 1'b0;
         end
      endcase
   end

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier LSB is set.
   always_comb begin
      prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Operand capture, multiplier iteration, result and flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         r_q      <= '0;
         led_q    <= 2'b00;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_pulse) begin
                  a_q      <= A;
                  b_q      <= B;
                  op_q     <= opCode;
                  cnt_q    <= CNT_W'(WIDTH - 1);
                  prod_q   <= '0;
                  mcand_q  <= {{WIDTH{1'b0}}, A};
                  mplier_q <= B;
               end
            end
            EXEC: begin
               if (op_q == OP_MUL) begin
                  prod_q   <= prod_step;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
                  if (cnt_q == '0) begin
                     r_q   <= RW'(prod_step);
                     led_q <= {(prod_step == '0), 1'b0};
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end else begin
                  r_q   <= res_alu;
                  led_q <= {(res_alu == '0), carry_alu};
               end
            end
            default: ;
         endcase
      end
   end

   assign led = led_q;

   // Display source mux, purely from registered state.
   always_comb begin
      case (select)
         SEL_RES:  Y = r_q;
         SEL_OPS:  Y = RW'({a_q, b_q});
         SEL_STAT: Y = RW'({op_q, state_q, led_q});
         default:  Y = '0;
      endcase
   end

endmodule

// File: tb/tb_bttn_alu_seq.sv
// Directed plus randomized bench for bttn_alu_seq (WIDTH=4, no debounce).
module tb_bttn_alu_seq;

   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [2:0]    opCode = '0;
   logic [1:0]    select = '0;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic [1:0]    led;
   logic [3*W-1:0] Y;

   int n_pass  = 0;
   int n_total = 0;

   // Reference state: result, flags and captured operands as the spec defines them.
   int m_r = 0, m_led = 0, m_a = 0, m_b = 0, m_op = 0;

   bttn_alu_seq #(.WIDTH(W), .DEB_CYCLES(16)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (A),
      .B      (B),
      .opCode (opCode),
      .select (select),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .led    (led),
      .Y      (Y)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Operation semantics computed with plain integer arithmetic.
   function automatic void ref_op(input int a, input int b, input int op, input int r_prev,
                                  output int r, output int c);
      int full;
      c = 0;
      case (op)
         0: begin r = a + b; c = (a + b > 15) ? 1 : 0; end
         1: begin r = (a - b) & 15; c = (a < b) ? 1 : 0; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = a * b;
         6: begin
            if (b >= 12) begin r = 0; c = (a != 0) ? 1 : 0; end
            else begin full = a << b; r = full & 'hFFF; c = ((full >> 12) != 0) ? 1 : 0; end
         end
         default: begin r = (r_prev + a) & 'hFFF; c = (r_prev + a > 'hFFF) ? 1 : 0; end
      endcase
   endfunction

   task automatic do_op(input int a, input int b, input int op, input bit glitch, input string tag);
      int exp_r, exp_c, exp_led, cyc, bcyc, extra;
      bit overlap;
      ref_op(a, b, op, m_r, exp_r, exp_c);
      exp_led = ((exp_r == 0) ? 2 : 0) | exp_c;
      @(negedge clk);
      A = 4'(a); B = 4'(b); opCode = 3'(op); start = 1'b1;
      cyc = 0;
      while (!busy && cyc < 20) begin @(negedge clk); cyc++; end
      check({tag, "_latency"}, 64'(cyc), 64'd3);
      // Operand inputs may wander once captured.
      A = 4'($urandom); B = 4'($urandom); opCode = 3'($urandom);
      bcyc = 0; overlap = 0;
      while (busy && bcyc < 20) begin
         if (done) overlap = 1;
         if (glitch && bcyc == 0) start = 1'b0;
         if (glitch && bcyc == 1) start = 1'b1;
         @(negedge clk); bcyc++;
      end
      check({tag, "_busy_cycles"}, 64'(bcyc), (op == 5) ? 64'd4 : 64'd1);
      check({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_result"}, 64'(Y), 64'(exp_r));
      check({tag, "_led"}, 64'(led), 64'(exp_led));
      m_r = exp_r; m_led = exp_led; m_a = a; m_b = b; m_op = op;
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      extra = 0;
      for (int i = 0; i < 5; i++) begin
         if (busy || done) extra++;
         @(negedge clk);
      end
      check({tag, "_no_retrigger"}, 64'(extra), 64'd0);
      start = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic check_view(input int sel, input string tag);
      int exp_y;
      case (sel)
         0: exp_y = m_r;
         1: exp_y = (m_a << 4) | m_b;
         2: exp_y = (m_op << 4) | m_led;
         default: exp_y = 0;
      endcase
      select = 2'(sel);
      #1;
      check(tag, 64'(Y), 64'(exp_y));
      select = 2'b00;
   endtask

   initial begin
      int cnt, a, b, op;
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_led", 64'(led), 64'd0);
      check("rst_y_res", 64'(Y), 64'd0);
      check_view(1, "rst_y_ops");
      check_view(2, "rst_y_stat");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed cases.
      do_op(15, 15, 0, 0, "add");
      check("add_value", 64'(Y), 64'h01E);
      do_op(0, 15, 1, 0, "sub");
      check_view(1, "sub_view_ops");
      do_op(15, 15, 5, 1, "mul");
      check("mul_value", 64'(Y), 64'h0E1);
      do_op(15, 1, 6, 0, "shl1");
      do_op(15, 12, 6, 0, "shl12");
      check("shl12_led", 64'(led), 64'b11);

      // Reset in the middle of a multiply.
      @(negedge clk);
      A = 4'd15; B = 4'd15; opCode = 3'd5; start = 1'b1;
      cnt = 0;
      while (!busy && cnt < 20) begin @(negedge clk); cnt++; end
      check("rstmul_busy_seen", 64'(busy), 64'd1);
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rstmul_busy", 64'(busy), 64'd0);
      check("rstmul_done", 64'(done), 64'd0);
      check("rstmul_led", 64'(led), 64'd0);
      check("rstmul_y", 64'(Y), 64'd0);
      m_r = 0; m_led = 0; m_a = 0; m_b = 0; m_op = 0;
      check_view(1, "rstmul_y_ops");
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (done || busy) cnt++;
         @(negedge clk);
      end
      check("rstmul_no_done", 64'(cnt), 64'd0);

      // Accumulate chaining from a cleared result.
      for (int i = 0; i < 3; i++) do_op(15, 0, 7, 0, "acc");
      check("acc_value", 64'(Y), 64'h02D);
      check_view(3, "acc_view_off");
      check_view(2, "acc_view_stat");

      // Randomized operations against the reference model.
      for (int i = 0; i < 16; i++) begin
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         op = int'($urandom_range(0, 7));
         do_op(a, b, op, 0, "rnd");
         check_view(int'($urandom_range(0, 3)), "rnd_view");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
